// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Widths here are defaults; modules may override via parameters.
package fetch_pkg;

  localparam int PC_W_DEF    = 18;
  localparam int INSTR_W_DEF = 33;
  localparam int PC_STEP_DEF = 4;

  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    F_REQ,
    F_WAIT,
    F_HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load,
// and an idle cycle inserts a bubble.
module fetch_ifid_reg
  import fetch_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               stall,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr,
  input  logic [PC_W-1:0]    pc,
  input  logic [PC_W-1:0]    pc_plus,
  output logic [INSTR_W-1:0] InstrD,
  output logic [PC_W-1:0]    PCD,
  output logic [PC_W-1:0]    PCPlus4D,
  output logic               ValidD
);

  localparam logic [INSTR_W-1:0] BUBBLE =
    INSTR_W'(NOP_INSTR);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      InstrD   <= BUBBLE;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (!stall) begin
      if (load) begin
        InstrD   <= instr;
        PCD      <= pc;
        PCPlus4D <= pc_plus;
        ValidD   <= 1'b1;
      end else begin
        InstrD   <= BUBBLE;
        PCD      <= '0;
        PCPlus4D <= '0;
        ValidD   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_cycle.sv
// Fetch stage: owns the PC, keeps one request in flight to imem,
// and feeds decode through the IF/ID register.
module fetch_cycle
  import fetch_pkg::*;
#(
  parameter int PC_W     = PC_W_DEF,
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int PC_STEP  = PC_STEP_DEF,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PCSrcE,
  input  logic [PC_W-1:0]    PCTargetE,
  input  logic               StallF,
  input  logic               StallD,
  input  logic               FlushD,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] InstrD,
  output logic [PC_W-1:0]    PCD,
  output logic [PC_W-1:0]    PCPlus4D,
  output logic               ValidD
);

  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);
  localparam logic [PC_W-1:0] PC0  = PC_W'(RESET_PC);

  fetch_state_t       state;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    fpc;
  logic               drop;
  logic [INSTR_W-1:0] hbuf;

  logic               accept;
  logic               rsp_ok;
  logic               ifid_load;
  logic [INSTR_W-1:0] ifid_instr;

  assign imem_req  = !rst && (state == F_REQ)
                     && !StallF && !PCSrcE;
  assign imem_addr = pc;
  assign accept    = imem_req && imem_ready;

  // A live response or the held one, unless a redirect kills it
  assign rsp_ok    = (state == F_WAIT) && imem_rvalid
                     && !drop && !PCSrcE;
  assign ifid_load = rsp_ok
                     || ((state == F_HOLD) && !PCSrcE);
  assign ifid_instr = (state == F_HOLD) ? hbuf
                                        : imem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= F_REQ;
      pc    <= PC0;
      fpc   <= PC0;
      drop  <= 1'b0;
      hbuf  <= '0;
    end else begin
      if (PCSrcE)
        pc <= PCTargetE;
      else if (accept)
        pc <= pc + STEP;

      unique case (state)
        F_REQ: begin
          if (accept) begin
            fpc   <= pc;
            state <= F_WAIT;
          end
        end
        F_WAIT: begin
          if (imem_rvalid) begin
            drop <= 1'b0;
            if (rsp_ok && StallD) begin
              hbuf  <= imem_rdata;
              state <= F_HOLD;
            end else begin
              state <= F_REQ;
            end
          end else if (PCSrcE) begin
            drop <= 1'b1;
          end
        end
        F_HOLD: begin
          if (PCSrcE || !StallD) begin
            hbuf  <= '0;
            state <= F_REQ;
          end
        end
        default: state <= F_REQ;
      endcase
    end
  end

  fetch_ifid_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_ifid (
    .clk      (clk),
    .rst      (rst),
    .load     (ifid_load),
    .stall    (StallD),
    .flush    (FlushD),
    .instr    (ifid_instr),
    .pc       (fpc),
    .pc_plus  (fpc + STEP),
    .InstrD   (InstrD),
    .PCD      (PCD),
    .PCPlus4D (PCPlus4D),
    .ValidD   (ValidD)
  );

endmodule

// File: tb/tb_fetch_cycle.sv
// Bench for fetch_cycle: directed scenarios then random traffic,
// checked each cycle against a transaction-level fetch model.
module tb_fetch_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrcE;
  logic [17:0] PCTargetE;
  logic        StallF, StallD, FlushD;
  logic        imem_req;
  logic [17:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [32:0] imem_rdata;
  logic [32:0] InstrD;
  logic [17:0] PCD, PCPlus4D;
  logic        ValidD;

  fetch_cycle dut (
    .clk(clk), .rst(rst),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // memory environment
  bit          want_ready;
  int          lat;
  bit          mem_busy;
  int          mem_cnt;
  logic [32:0] mem_data;
  bit          force_v;
  logic [32:0] force_d;
  logic [17:0] acc_q[$];

  // reference model: one in-flight fetch, optional parked word
  logic [17:0] m_pc, m_fpc;
  bit          m_out, m_have, m_drop;
  logic [32:0] m_buf, m_instr;
  logic [17:0] m_pcd, m_pc4;
  logic        m_vd;
  logic        exp_req;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] qget(int i);
    if (i < acc_q.size()) return acc_q[i];
    return 'x;
  endfunction

  task automatic m_bubble();
    m_instr = '0; m_pcd = '0; m_pc4 = '0; m_vd = 1'b0;
  endtask

  task automatic model_step();
    logic        ov;
    logic [32:0] od;
    if (rst) begin
      m_pc = 18'h0; m_out = 0; m_have = 0; m_drop = 0;
      m_bubble();
      return;
    end
    ov = 0; od = '0;
    if (!PCSrcE && m_out && imem_rvalid && !m_drop) begin
      ov = 1; od = imem_rdata;
    end
    if (!PCSrcE && m_have) begin
      ov = 1; od = m_buf;
    end
    if (FlushD) m_bubble();
    else if (!StallD) begin
      if (ov) begin
        m_instr = od; m_pcd = m_fpc;
        m_pc4 = m_fpc + 18'd4; m_vd = 1'b1;
      end else m_bubble();
    end
    if (PCSrcE) begin
      if (m_out) begin
        if (imem_rvalid) begin m_out = 0; m_drop = 0; end
        else m_drop = 1;
      end
      m_have = 0;
      m_pc = PCTargetE;
    end else if (m_out && imem_rvalid) begin
      m_out = 0;
      if (m_drop) m_drop = 0;
      else if (StallD) begin m_have = 1; m_buf = imem_rdata; end
    end else if (m_have) begin
      if (!StallD) m_have = 0;
    end else if (exp_req && imem_ready) begin
      m_fpc = m_pc; m_pc = m_pc + 18'd4; m_out = 1;
    end
  endtask

  task automatic tick();
    bit acc;
    imem_rvalid = mem_busy && (mem_cnt == 0);
    imem_rdata  = imem_rvalid ? mem_data
                : {1'($urandom), 32'($urandom)};
    imem_ready  = want_ready && !mem_busy;
    #1;
    exp_req = !rst && !m_out && !m_have && !StallF && !PCSrcE;
    chk("imem_req", {63'd0, imem_req}, {63'd0, exp_req});
    if (exp_req) chk("imem_addr", 64'(imem_addr), 64'(m_pc));
    acc = imem_req && imem_ready;
    if (acc) acc_q.push_back(imem_addr);
    @(posedge clk);
    model_step();
    if (imem_rvalid) mem_busy = 0;
    else if (mem_busy) mem_cnt--;
    if (acc) begin
      mem_busy = 1;
      mem_cnt  = lat - 1;
      mem_data = force_v ? force_d
               : {1'($urandom), 32'($urandom)};
      force_v  = 0;
    end
    #1;
    chk("InstrD", 64'(InstrD), 64'(m_instr));
    chk("PCD", 64'(PCD), 64'(m_pcd));
    chk("PCPlus4D", 64'(PCPlus4D), 64'(m_pc4));
    chk("ValidD", {63'd0, ValidD}, {63'd0, m_vd});
  endtask

  task automatic wait_out();
    int k = 0;
    while (!m_out && k < 20) begin tick(); k++; end
    chk("wait_accept", {63'd0, m_out}, 64'd1);
  endtask

  task automatic idle();
    int k = 0;
    while ((m_out || m_have) && k < 30) begin tick(); k++; end
    chk("wait_idle", {63'd0, (m_out || m_have)}, 64'd0);
  endtask

  initial begin
    logic [17:0] drop_pc;
    bit seen;
    int k;
    rst = 1; PCSrcE = 0; PCTargetE = '0;
    StallF = 0; StallD = 0; FlushD = 0;
    want_ready = 1; lat = 1;
    mem_busy = 0; mem_cnt = 0; mem_data = '0; force_v = 0;

    tick(); tick();
    chk("rst_valid", {63'd0, ValidD}, 64'd0);
    chk("rst_instr", 64'(InstrD), 64'd0);

    // zero-wait memory
    rst = 0; acc_q.delete();
    repeat (7) tick();
    chk("zw_a0", 64'(qget(0)), 64'h00000);
    chk("zw_a1", 64'(qget(1)), 64'h00004);
    chk("zw_a2", 64'(qget(2)), 64'h00008);

    // slow memory
    lat = 3;
    repeat (10) tick();

    // redirect while waiting
    idle(); lat = 3; wait_out();
    drop_pc = m_fpc;
    acc_q.delete();
    PCSrcE = 1; PCTargetE = 18'h00100;
    tick();
    PCSrcE = 0;
    k = 0;
    while (acc_q.size() == 0 && k < 20) begin
      tick(); k++;
      chk("drop_leak", {63'd0, ValidD && PCD == drop_pc}, 64'd0);
    end
    chk("redir_addr", 64'(qget(0)), 64'h00100);

    // decode stall holding a response
    idle(); lat = 1;
    force_v = 1; force_d = 33'h1ABCDEF01;
    wait_out();
    StallD = 1;
    repeat (4) tick();
    StallD = 0;
    tick();
    chk("stall_instr", 64'(InstrD), 64'h1ABCDEF01);
    chk("stall_valid", {63'd0, ValidD}, 64'd1);

    // flush wins over stall
    FlushD = 1; StallD = 1;
    tick();
    chk("flush_instr", 64'(InstrD), 64'd0);
    chk("flush_valid", {63'd0, ValidD}, 64'd0);
    FlushD = 0; StallD = 0;

    // PC wrap
    idle(); lat = 1; acc_q.delete();
    PCSrcE = 1; PCTargetE = 18'h3FFFC;
    tick();
    PCSrcE = 0; seen = 0; k = 0;
    while (acc_q.size() < 2 && k < 20) begin
      tick(); k++;
      if (ValidD && PCD == 18'h3FFFC) begin
        seen = 1;
        chk("wrap_pc4", 64'(PCPlus4D), 64'h00000);
      end
    end
    chk("wrap_seen", {63'd0, seen}, 64'd1);
    chk("wrap_a0", 64'(qget(0)), 64'h3FFFC);
    chk("wrap_a1", 64'(qget(1)), 64'h00000);

    // reset mid-wait, late response ignored
    idle(); lat = 4; wait_out();
    tick();
    rst = 1; tick(); rst = 0;
    acc_q.delete(); k = 0;
    while (acc_q.size() == 0 && k < 20) begin
      tick(); k++;
    end
    chk("rst_addr", 64'(qget(0)), 64'h00000);

    // random traffic
    repeat (600) begin
      lat        = $urandom_range(1, 4);
      want_ready = ($urandom_range(0, 9) < 8);
      StallF     = ($urandom_range(0, 9) < 2);
      StallD     = ($urandom_range(0, 3) == 0);
      FlushD     = ($urandom_range(0, 9) == 0);
      PCSrcE     = ($urandom_range(0, 99) < 8);
      PCTargetE  = 18'($urandom) & 18'h3FFFC;
      rst        = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
